injection_scheduler: RTL and testbench
======================================

INJECTION_SCHEDULER -- requirements
Module: injection_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of terminal requesters; requester i owns VC i.
REQ-002 Parameter NUM_VCS, default 4: VCs on the injection channel; SHALL equal NUM_REQ.
REQ-003 Parameter BUF_DEPTH, default 8: router input buffer depth per VC, i.e. the initial credit count.
REQ-004 Parameter PAYLOAD_W, default 64: payload bits per flit.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NUM_REQ  requester i has a flit offered.
REQ-008 req_head  input  NUM_REQ  offered flit is a packet head.
REQ-009 req_tail  input  NUM_REQ  offered flit is a packet tail; head and tail both set means a single-flit packet.
REQ-010 req_payload  input  NUM_REQ*PAYLOAD_W  payloads; requester i uses bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-011 req_ready  output  NUM_REQ  grant; a flit transfers in a cycle with req_valid[i] and req_ready[i] both high.
REQ-012 channel_out  output  [0:68]  to router injection channel_in: bit0 valid, bit1 head, bit2 tail, bits3:4 VC, bits5:68 payload.
REQ-013 flow_ctrl_in  input  [0:2]  credit return from router flow_ctrl_out: bit0 credit valid, bits1:2 VC.
REQ-014 error  output  1  sticky protocol/credit error flag.

Function
REQ-015 Per-VC credit counters SHALL cover the range 0..BUF_DEPTH.
- Send on VC v: credit[v] decrements by 1.
- Credit return on VC v: credit[v] increments by 1.
- Send and return on the same VC in the same cycle: credit[v] is unchanged.
REQ-016 Requester i is eligible when req_valid[i]=1 and credit[i]>0. The credit value is the registered value; a return takes effect the next cycle.
REQ-017 Arbitration SHALL be round-robin, one grant per cycle at most.
- Search starts at rr_ptr.
- After a grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ.
- With no grant, rr_ptr holds.
REQ-018 req_ready SHALL be combinational from the current eligibility and rr_ptr, and one-hot or zero.
- req_ready[i] is never high while credit[i]=0.
- req_ready is independent of req_head and req_tail.
REQ-019 Latency is 1 cycle: the flit granted in cycle N appears on channel_out registered in cycle N+1, with valid=1, head/tail copied, VC=i and payload copied.
REQ-020 In any cycle after a cycle with no grant, channel_out SHALL be all zeros.
REQ-021 Flits from different requesters MAY interleave cycle by cycle, because VCs are private; there is no packet lock across requesters.
REQ-022 Each requester has a packet-state FSM with states IDLE and IN_PKT.
- IDLE, head without tail -> IN_PKT.
- IDLE, head with tail -> IDLE.
- IN_PKT, tail -> IDLE.
- Otherwise the state holds.
- The FSM advances only on transferred flits.
REQ-023 The following SHALL set error:
- a transferred head flit while IN_PKT;
- a transferred non-head flit while IDLE.
The offending flit is still forwarded unchanged.
REQ-024 A credit return on a VC whose counter equals BUF_DEPTH SHALL set error; the counter saturates at BUF_DEPTH. This applies unless the same VC sends in that cycle, in which case REQ-015 applies and no error is raised.
REQ-025 error SHALL stay at 1 until reset.

Reset
REQ-026 While reset=0, asynchronously and independent of clk:
- channel_out=0, req_ready=0, error=0;
- credit[v]=BUF_DEPTH for all v;
- rr_ptr=0;
- all FSMs in IDLE.
REQ-027 Reset asserted mid-packet SHALL discard all packet state; no partial flit appears on channel_out after reset assertion.
REQ-028 The first grant is possible in the first rising edge after reset deasserts.

Verification
REQ-029 After reset, req0 offers head+tail with payload 0xA5 -> req_ready[0]=1 that cycle; the next cycle channel_out shows valid=1, head=1, tail=1, VC=0, payload=0xA5; error=0.
REQ-030 All four requesters valid continuously with credits available -> grants in the order 0,1,2,3,0,1 on consecutive cycles, one per cycle.
REQ-031 req1 streams a 9-flit packet with no credit returns -> 8 flits are granted and req_ready[1]=0 on the 9th offer. A credit return on VC1 -> the 9th flit is granted the following cycle.
REQ-032 After one send on VC2 (credit=7), apply a simultaneous VC2 send and VC2 credit return -> credit stays 7; no error.
REQ-033 Credit return on VC3 with no prior sends -> error=1 the next cycle, still 1 after 10 idle cycles; credit[3]=8.
REQ-034 Assert reset during req0's body flit -> channel_out=0 immediately. After release, req0 sends a non-head flit -> error=1 and the flit is forwarded.

Source files
------------

// File: rtl/injection_scheduler.sv
// Injection scheduler: round-robin arbitration of NUM_REQ terminal requesters
// onto a single router injection channel. Each requester owns one VC. The block
// tracks per-VC credits and per-requester packet framing.

// Per-requester lane: credit counter and packet-framing FSM for one VC.
module injection_lane #(
    parameter int BUF_DEPTH = 8,
    parameter int CRED_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic send_i,       // flit from this requester transfers this cycle
    input  logic head_i,
    input  logic tail_i,
    input  logic ret_i,        // credit returned on this VC this cycle
    output logic has_credit_o,
    output logic err_o         // framing or credit-overflow error this cycle
);
    typedef enum logic {IDLE, IN_PKT} pkt_state_e;

    pkt_state_e        state_q, state_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic              proto_err, ovf_err;

    assign has_credit_o = (credit_q != '0);
    assign err_o        = proto_err | ovf_err;

    // State and credit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= CRED_W'(BUF_DEPTH);
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    // Packet framing: advance only on transferred flits, flag bad framing
    always_comb begin
        state_d   = state_q;
        proto_err = 1'b0;
        if (send_i) begin
            case (state_q)
                IDLE: begin
                    if (!head_i)     proto_err = 1'b1;
                    else if (!tail_i) state_d  = IN_PKT;
                end
                IN_PKT: begin
                    if (head_i) proto_err = 1'b1;
                    if (tail_i) state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Credit accounting; a send and a return in the same cycle cancel out
    always_comb begin
        credit_d = credit_q;
        ovf_err  = 1'b0;
        if (send_i && !ret_i) begin
            credit_d = credit_q - CRED_W'(1);
        end else if (ret_i && !send_i) begin
            if (credit_q == CRED_W'(BUF_DEPTH)) ovf_err  = 1'b1;
            else                                credit_d = credit_q + CRED_W'(1);
        end
    end
endmodule

module injection_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_VCS   = 4,
    parameter int BUF_DEPTH = 8,
    parameter int PAYLOAD_W = 64,
    parameter int VC_W      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    parameter int CH_W      = 3 + VC_W + PAYLOAD_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_head,
    input  logic [NUM_REQ-1:0]             req_tail,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [0:CH_W-1]                channel_out,
    input  logic [0:VC_W]                  flow_ctrl_in,
    output logic                           error
);
    logic [NUM_REQ-1:0] has_credit, ret, lane_err, elig, grant;
    logic [VC_W-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx;
    logic               gnt_vld;
    logic [0:CH_W-1]    channel_q, channel_d;
    logic               error_q, error_d;

    assign elig        = req_valid & has_credit;
    assign req_ready   = grant;
    assign channel_out = channel_q;
    assign error       = error_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign ret[i] = flow_ctrl_in[0] && (flow_ctrl_in[1:VC_W] == VC_W'(i));
        injection_lane #(.BUF_DEPTH(BUF_DEPTH)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .send_i       (grant[i]),
            .head_i       (req_head[i]),
            .tail_i       (req_tail[i]),
            .ret_i        (ret[i]),
            .has_credit_o (has_credit[i]),
            .err_o        (lane_err[i])
        );
    end

    // Round-robin search from rr_ptr; gated by reset so nothing is granted while held
    always_comb begin : arb
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_vld && elig[idx[VC_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx[VC_W-1:0];
                end
            end
        end
        grant = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    // Next pointer, outgoing flit and sticky error
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        channel_d = '0;
        if (gnt_vld) begin
            rr_ptr_d  = (gnt_idx == VC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + VC_W'(1);
            channel_d = {1'b1, req_head[gnt_idx], req_tail[gnt_idx], gnt_idx,
                         req_payload[gnt_idx*PAYLOAD_W +: PAYLOAD_W]};
        end
        error_d = error_q | (|lane_err);
    end

    // Output flit register, arbitration pointer and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            channel_q <= '0;
            error_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            channel_q <= channel_d;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_injection_scheduler.sv
module tb_injection_scheduler;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_valid, req_head, req_tail, req_ready;
    logic [255:0] req_payload;
    logic [0:68]  channel_out;
    logic [0:2]   flow_ctrl_in;
    logic         error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    injection_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_head     (req_head),
        .req_tail     (req_tail),
        .req_payload  (req_payload),
        .req_ready    (req_ready),
        .channel_out  (channel_out),
        .flow_ctrl_in (flow_ctrl_in),
        .error        (error)
    );

    function automatic logic [0:68] mk(input logic h, input logic t,
                                       input logic [1:0] vc, input logic [63:0] pl);
        return {1'b1, h, t, vc, pl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid    = '0;
        req_head     = '0;
        req_tail     = '0;
        req_payload  = '0;
        flow_ctrl_in = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset     = 1'b0;
        req_valid = 4'hF;
        req_head  = 4'hF;
        req_tail  = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_checks++;
        if (channel_out !== 69'd0) begin n_fail++; $display("FAIL reset_channel got %h want 0", channel_out); end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        idle_inputs();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        req_valid = 4'b0001; req_head = 4'b0001; req_tail = 4'b0001;
        req_payload[63:0] = 64'hA5;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        idle_inputs();
        n_checks++;
        if (channel_out !== mk(1'b1, 1'b1, 2'd0, 64'hA5))
            begin n_fail++; $display("FAIL single_flit got %h want %h", channel_out, mk(1'b1, 1'b1, 2'd0, 64'hA5)); end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL single_error got %b want 0", error); end
        tick();
        n_checks++;
        if (channel_out !== 69'd0) begin n_fail++; $display("FAIL single_idle got %h want 0", channel_out); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        do_reset();
        req_valid = 4'hF; req_head = 4'hF; req_tail = 4'hF;
        for (int i = 0; i < 4; i++) req_payload[i*64 +: 64] = 64'(i + 1);
        for (int c = 0; c < 6; c++) begin
            exp = 4'b0001 << (c % 4);
            #1;
            n_checks++;
            if (req_ready !== exp) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, exp); end
            tick();
            n_checks++;
            if (channel_out !== mk(1'b1, 1'b1, 2'(c % 4), 64'((c % 4) + 1)))
                begin n_fail++; $display("FAIL rr_flit[%0d] got %h want %h", c, channel_out, mk(1'b1, 1'b1, 2'(c % 4), 64'((c % 4) + 1))); end
        end
        idle_inputs();
    endtask

    task automatic test_credit_exhaust;
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            req_head = (k == 0) ? 4'b0010 : 4'b0000;
            req_tail = (k == 8) ? 4'b0010 : 4'b0000;
            req_payload[127:64] = 64'(100 + k);
            #1;
            n_checks++;
            if (req_ready !== ((k < 8) ? 4'b0010 : 4'b0000))
                begin n_fail++; $display("FAIL exhaust_ready[%0d] got %b", k, req_ready); end
            if (k < 8) begin
                tick();
                n_checks++;
                if (channel_out !== mk(k == 0, 1'b0, 2'd1, 64'(100 + k)))
                    begin n_fail++; $display("FAIL exhaust_flit[%0d] got %h want %h", k, channel_out, mk(k == 0, 1'b0, 2'd1, 64'(100 + k))); end
            end
        end
        flow_ctrl_in = {1'b1, 2'd1};
        tick();
        flow_ctrl_in = '0;
        n_checks++;
        if (channel_out !== 69'd0) begin n_fail++; $display("FAIL exhaust_stall_chan got %h want 0", channel_out); end
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL exhaust_after_ret got %b want 0010", req_ready); end
        tick();
        idle_inputs();
        n_checks++;
        if (channel_out !== mk(1'b0, 1'b1, 2'd1, 64'd108))
            begin n_fail++; $display("FAIL exhaust_tail got %h want %h", channel_out, mk(1'b0, 1'b1, 2'd1, 64'd108)); end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL exhaust_error got %b want 0", error); end
    endtask

    task automatic test_simul_send_return;
        do_reset();
        req_valid = 4'b0100; req_head = 4'b0100; req_tail = 4'b0100;
        req_payload[191:128] = 64'd7;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL simul_first got %b want 0100", req_ready); end
        tick();
        flow_ctrl_in = {1'b1, 2'd2};
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL simul_both got %b want 0100", req_ready); end
        tick();
        flow_ctrl_in = '0;
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL simul_error got %b want 0", error); end
        // credit must still be 7: exactly seven more grants
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (req_ready !== ((k < 7) ? 4'b0100 : 4'b0000))
                begin n_fail++; $display("FAIL simul_drain[%0d] got %b", k, req_ready); end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL simul_error_end got %b want 0", error); end
    endtask

    task automatic test_credit_overflow;
        do_reset();
        flow_ctrl_in = {1'b1, 2'd3};
        tick();
        flow_ctrl_in = '0;
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error got %b want 1", error); end
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", error); end
        // credit saturated at 8: eight grants then stall
        req_valid = 4'b1000; req_head = 4'b1000; req_tail = 4'b1000;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_checks++;
            if (req_ready !== ((k < 8) ? 4'b1000 : 4'b0000))
                begin n_fail++; $display("FAIL ovf_drain[%0d] got %b", k, req_ready); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        req_valid = 4'b0001; req_head = 4'b0001; req_tail = 4'b0000;
        req_payload[63:0] = 64'h11;
        tick();
        req_head = 4'b0000;
        req_payload[63:0] = 64'h22;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_body_ready got %b want 0001", req_ready); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (channel_out !== 69'd0) begin n_fail++; $display("FAIL mid_reset_chan got %h want 0", channel_out); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
        idle_inputs();
        tick();
        reset = 1'b1;
        req_valid = 4'b0001;
        req_payload[63:0] = 64'h33;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_ready got %b want 0001", req_ready); end
        tick();
        idle_inputs();
        n_checks++;
        if (channel_out !== mk(1'b0, 1'b0, 2'd0, 64'h33))
            begin n_fail++; $display("FAIL mid_post_flit got %h want %h", channel_out, mk(1'b0, 1'b0, 2'd0, 64'h33)); end
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL mid_post_error got %b want 1", error); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_credit_exhaust();
        test_simul_send_return();
        test_credit_overflow();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
